control_alarma: RTL
===================

# control_alarma

Alarm response controller for the alarm clock. Consumes the time/alarm match flag from the alarm comparator and turns it into a buzzer drive with stop, snooze and automatic timeout. Sits between the comparator and the buzzer pin; minute and tone timing come from pulses produced by the clock's existing divider chain.

## Interface
- SNOOZE_MIN, 5: minutes spent in snooze before ringing resumes (1..15)
- RING_MAX_MIN, 10: minutes of unattended ringing before automatic stop (1..15)
- MAX_SNOOZES, 3: snoozes allowed per alarm event (0..7)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enc  in  1  match flag from comparator; level, high for the whole matching minute
- alarma_en  in  1  alarm armed switch, already synchronous to clk
- btn_stop  in  1  one-cycle pulse, debounced upstream
- btn_snooze  in  1  one-cycle pulse, debounced upstream
- tick_min  in  1  one-cycle pulse once per minute
- tick_tono  in  1  one-cycle pulse at twice the buzzer tone frequency
- buzzer  out  1  registered buzzer drive
- sonando  out  1  high while state is RING
- pospuesto  out  1  high while state is SNOOZE

## Operation
- enc registered into enc_q every cycle; trigger = enc & ~enc_q & alarma_en.
- States: IDLE, RING, SNOOZE.
- IDLE: trigger -> RING; ring_min, snooze_cnt cleared.
- RING, priority highest first: btn_stop -> IDLE; ~alarma_en -> IDLE; btn_snooze with snooze_cnt < MAX_SNOOZES -> SNOOZE (sn_min := 0, snooze_cnt += 1); tick_min -> ring_min += 1, and if new value == RING_MAX_MIN -> IDLE.
- btn_snooze in RING with snooze_cnt == MAX_SNOOZES: ignored, keeps ringing.
- SNOOZE: btn_stop or ~alarma_en -> IDLE; tick_min -> sn_min += 1, and if new value == SNOOZE_MIN -> RING with ring_min := 0.
- New trigger while in RING or SNOOZE: ignored.
- Tone: in RING, tone_ff toggles and 4-bit cadence counter increments on each tick_tono; buzzer <= tone_ff & ~cadence[3] (8 toggles on, 8 silent). Outside RING tone_ff, cadence, buzzer forced 0.
- Counters sized to hold their parameter; they never wrap since transitions fire at equality.

## Timing
- Reset: state IDLE, enc_q = 1 (suppresses firing if reset is released inside the matching minute), all counters 0, buzzer 0, sonando 0, pospuesto 0.
- enc rising seen at edge N -> sonando high after edge N.
- sonando, pospuesto decoded from the state register, no extra latency.
- buzzer: one cycle behind its state/tone conditions; low the cycle after leaving RING.
- btn_stop, btn_snooze, tick_min coincident: priority order above, one action per cycle.
- Reset asserted mid-ring: immediate return to reset values, no pending snooze kept.

## Configuration
- CONTROL_ALARMA_SNOOZE_EN defined: snooze behaviour as above.
- Not defined: SNOOZE state, sn_min and snooze_cnt absent; btn_snooze ignored; pospuesto tied 0; RING leaves only by stop, disarm or timeout.

## Structure
- Shared package: state encoding (IDLE, RING, SNOOZE) and parameter defaults, so the top level and bench share them.
- One natural sub-module: generador_tono (tone_ff plus cadence counter, enable = state RING, output buzzer).

## Test plan
- enc 0->1 with alarma_en=1 -> sonando=1 next cycle; buzzer toggles on tick_tono with 8-on/8-off cadence.
- Ringing, 10 tick_min with no buttons -> IDLE exactly on 10th tick, buzzer 0 next cycle.
- btn_snooze in RING -> pospuesto=1; 5 tick_min -> RING again; 4th snooze request ignored.
- btn_stop and btn_snooze same cycle -> IDLE, snooze_cnt 0; enc stays high -> no re-trigger in the same minute.
- Release rst_n while enc=1 -> stays IDLE; next enc 0->1 -> RING.
- alarma_en dropped during SNOOZE -> IDLE; enc edge with alarma_en=0 -> no ring.

Source files
------------

// File: rtl/control_alarma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_alarma_pkg
// Description : Shared state encoding and parameter defaults for the alarm
//               response controller and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package control_alarma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } estado_t;

  localparam int c_snooze_min_def   = 5;
  localparam int c_ring_max_min_def = 10;
  localparam int c_max_snoozes_def  = 3;

  // Minute counters hold up to 15, snooze count up to 7, cadence is 16 steps.
  localparam int c_min_w = 4;
  localparam int c_snz_w = 3;
  localparam int c_cad_w = 4;

endpackage
`default_nettype wire

// File: rtl/control_alarma_generador_tono.sv
`default_nettype none
// ============================================================================
// Module      : generador_tono
// Description : Buzzer tone generator: square wave from tick_tono, gated by
//               an 8-on / 8-off cadence, cleared whenever en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module generador_tono
  import control_alarma_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick_tono,
  output logic buzzer
);

  logic               r_tone_ff;
  logic [c_cad_w-1:0] r_cadence;
  logic               r_buzzer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_ff <= 1'b0;
      r_cadence <= '0;
      r_buzzer  <= 1'b0;
    end else if (!en) begin
      r_tone_ff <= 1'b0;
      r_cadence <= '0;
      r_buzzer  <= 1'b0;
    end else begin
      // Upper cadence bit mutes the second half of each 16-toggle period.
      r_buzzer <= r_tone_ff & ~r_cadence[c_cad_w-1];
      if (tick_tono) begin
        r_tone_ff <= ~r_tone_ff;
        r_cadence <= r_cadence + c_cad_w'(1);
      end
    end
  end

  assign buzzer = r_buzzer;

endmodule
`default_nettype wire

// File: rtl/control_alarma.sv
`default_nettype none
// ============================================================================
// Module      : control_alarma
// Description : Alarm response controller: turns the comparator match flag
//               into buzzer drive with stop, snooze and ring timeout.
//               Snooze support is built only with CONTROL_ALARMA_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module control_alarma
  import control_alarma_pkg::*;
#(
  parameter int SNOOZE_MIN   = c_snooze_min_def,
  parameter int RING_MAX_MIN = c_ring_max_min_def,
  parameter int MAX_SNOOZES  = c_max_snoozes_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc,
  input  logic alarma_en,
  input  logic btn_stop,
  input  logic btn_snooze,
  input  logic tick_min,
  input  logic tick_tono,
  output logic buzzer,
  output logic sonando,
  output logic pospuesto
);

  localparam logic [c_min_w-1:0] c_ring_max = c_min_w'(RING_MAX_MIN);

  estado_t              r_estado, w_estado;
  logic                 r_enc_q;
  logic                 w_trigger;
  logic [c_min_w-1:0]   r_ring_min, w_ring_min, w_ring_inc;

`ifdef CONTROL_ALARMA_SNOOZE_EN
  localparam logic [c_min_w-1:0] c_snooze_min  = c_min_w'(SNOOZE_MIN);
  localparam logic [c_snz_w-1:0] c_max_snoozes = c_snz_w'(MAX_SNOOZES);

  logic [c_min_w-1:0]   r_sn_min, w_sn_min, w_sn_inc;
  logic [c_snz_w-1:0]   r_snooze_cnt, w_snooze_cnt;
`else
  logic [c_min_w+c_snz_w:0] w_unused_snooze;
  assign w_unused_snooze = {btn_snooze, c_min_w'(SNOOZE_MIN), c_snz_w'(MAX_SNOOZES)};
`endif

  // enc_q resets high so a reset released mid-minute does not fire.
  assign w_trigger = enc & ~r_enc_q & alarma_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado     <= IDLE;
      r_enc_q      <= 1'b1;
      r_ring_min   <= '0;
`ifdef CONTROL_ALARMA_SNOOZE_EN
      r_sn_min     <= '0;
      r_snooze_cnt <= '0;
`endif
    end else begin
      r_estado     <= w_estado;
      r_enc_q      <= enc;
      r_ring_min   <= w_ring_min;
`ifdef CONTROL_ALARMA_SNOOZE_EN
      r_sn_min     <= w_sn_min;
      r_snooze_cnt <= w_snooze_cnt;
`endif
    end
  end

  always_comb begin
    w_estado     = r_estado;
    w_ring_min   = r_ring_min;
    w_ring_inc   = r_ring_min + c_min_w'(1);
`ifdef CONTROL_ALARMA_SNOOZE_EN
    w_sn_min     = r_sn_min;
    w_sn_inc     = r_sn_min + c_min_w'(1);
    w_snooze_cnt = r_snooze_cnt;
`endif
    case (r_estado)
      IDLE: begin
        if (w_trigger) begin
          w_estado     = RING;
          w_ring_min   = '0;
`ifdef CONTROL_ALARMA_SNOOZE_EN
          w_snooze_cnt = '0;
`endif
        end
      end
      RING: begin
        if (btn_stop || !alarma_en) begin
          w_estado = IDLE;
`ifdef CONTROL_ALARMA_SNOOZE_EN
        end else if (btn_snooze && (r_snooze_cnt < c_max_snoozes)) begin
          w_estado     = SNOOZE;
          w_sn_min     = '0;
          w_snooze_cnt = r_snooze_cnt + c_snz_w'(1);
`endif
        end else if (tick_min) begin
          w_ring_min = w_ring_inc;
          if (w_ring_inc == c_ring_max) begin
            w_estado = IDLE;
          end
        end
      end
`ifdef CONTROL_ALARMA_SNOOZE_EN
      SNOOZE: begin
        if (btn_stop || !alarma_en) begin
          w_estado = IDLE;
        end else if (tick_min) begin
          w_sn_min = w_sn_inc;
          if (w_sn_inc == c_snooze_min) begin
            w_estado   = RING;
            w_ring_min = '0;
          end
        end
      end
`endif
      default: w_estado = IDLE;
    endcase
  end

  assign sonando = (r_estado == RING);
`ifdef CONTROL_ALARMA_SNOOZE_EN
  assign pospuesto = (r_estado == SNOOZE);
`else
  assign pospuesto = 1'b0;
`endif

  generador_tono u_tono (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (sonando),
    .tick_tono (tick_tono),
    .buzzer    (buzzer)
  );

endmodule
`default_nettype wire
